// File: rtl/dcca_seq.sv
// Clock-enable sequencer for the DCCA clock buffers: synchronises per-channel
// requests, applies disable hysteresis and staggers CE changes round-robin.
module dcca_seq #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER     = 4,
    parameter int HOLD        = 8
) (
    input  logic           CLKI,
    input  logic           RSTN,
    input  logic [NCH-1:0] CE_REQ,
    input  logic           FORCE,
    output logic [NCH-1:0] CE_OUT,
    output logic [NCH-1:0] CE_ACK,
    output logic           BUSY
);

    localparam int HW_RAW = $clog2(HOLD + 1);
    localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam int SW_RAW = $clog2(STAGGER);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int PW_RAW = $clog2(NCH);
    localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;

    localparam int unsigned NCHU   = NCH;
    localparam logic [HW-1:0] HOLD_V  = HW'(HOLD);
    localparam logic [SW-1:0] SPACE_V = SW'(STAGGER - 1);

    typedef enum logic {
        IDLE,
        SPACE
    } state_t;

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] req_s;
    logic [HW-1:0]  hold_q [NCH];
    logic [NCH-1:0] hold_done;
    logic [NCH-1:0] target;
    logic [NCH-1:0] pending;
    logic [PW-1:0]  sel;
    logic           sel_found;

    state_t         state_q, state_d;
    logic [SW-1:0]  space_q, space_d;
    logic [NCH-1:0] ce_q, ce_d;
    logic [NCH-1:0] ack_q;
    logic [PW-1:0]  ptr_q, ptr_d;

    // Channel index p+k wrapped into 0..NCH-1 (NCH need not be a power of two).
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        while (s >= NCHU) s = s - NCHU;
        return PW'(s);
    endfunction

    always_ff @(posedge CLKI) begin
        if (!RSTN) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= CE_REQ;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLKI) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!RSTN || FORCE || req_s[i]) begin
                hold_q[i] <= '0;
            end else if (hold_q[i] != HOLD_V) begin
                hold_q[i] <= hold_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        hold_done = '0;
        target    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hold_done[i] = !req_s[i] && (hold_q[i] == HOLD_V);
            target[i]    = req_s[i] ? 1'b1 : (hold_done[i] ? 1'b0 : ce_q[i]);
        end
    end

    assign pending = target ^ ce_q;

    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!sel_found && pending[wrap_add(ptr_q, k)]) begin
                sel_found = 1'b1;
                sel       = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        space_d = space_q;
        ce_d    = ce_q;
        ptr_d   = ptr_q;
        if (FORCE) begin
            ce_d    = '1;
            state_d = IDLE;
            space_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        ce_d[sel] = target[sel];
                        ptr_d     = wrap_add(sel, 1);
                        if (STAGGER > 1) begin
                            state_d = SPACE;
                            space_d = SPACE_V;
                        end
                    end
                end
                SPACE: begin
                    if (space_q <= SW'(1)) begin
                        state_d = IDLE;
                        space_d = '0;
                    end else begin
                        space_d = space_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    space_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLKI) begin
        if (!RSTN) begin
            state_q <= IDLE;
            space_q <= '0;
            ce_q    <= '0;
            ack_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            space_q <= space_d;
            ce_q    <= ce_d;
            ack_q   <= ce_q;
            ptr_q   <= ptr_d;
        end
    end

    assign CE_OUT = ce_q;
    assign CE_ACK = ack_q;
    assign BUSY   = (state_q == SPACE) || (|pending);

endmodule

// File: tb/tb_dcca_seq.sv
// Directed bench for dcca_seq: expected outputs are queued with the edge they
// are due on and checked when the bench reaches that edge.
module tb_dcca_seq;

    localparam int K_OUT  = 0;
    localparam int K_ACK  = 1;
    localparam int K_BUSY = 2;
    localparam int K_OUT2 = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] val;
        string      tag;
    } exp_t;

    logic       CLKI;
    logic       RSTN, FORCE, BUSY;
    logic [3:0] CE_REQ, CE_OUT, CE_ACK;
    logic       rstn2, force2, busy2;
    logic [3:0] req2, out2, ack2;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   base        = 0;
    exp_t sb[$];

    dcca_seq #(.NCH(4), .SYNC_STAGES(2), .STAGGER(4), .HOLD(8)) dut (
        .CLKI(CLKI), .RSTN(RSTN), .CE_REQ(CE_REQ), .FORCE(FORCE),
        .CE_OUT(CE_OUT), .CE_ACK(CE_ACK), .BUSY(BUSY)
    );

    dcca_seq #(.NCH(4), .SYNC_STAGES(2), .STAGGER(4), .HOLD(0)) dut_h0 (
        .CLKI(CLKI), .RSTN(rstn2), .CE_REQ(req2), .FORCE(force2),
        .CE_OUT(out2), .CE_ACK(ack2), .BUSY(busy2)
    );

    initial begin
        CLKI = 1'b0;
        forever #5 CLKI = ~CLKI;
    end

    function automatic logic [3:0] observe(input int kind);
        case (kind)
            K_OUT:   return CE_OUT;
            K_ACK:   return CE_ACK;
            K_BUSY:  return {3'b000, BUSY};
            default: return out2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_at(input int rel, input int kind, input logic [3:0] v, input string name);
        sb.push_back('{cyc: base + rel, kind: kind, val: v, tag: $sformatf("%s+%0d", name, rel)});
    endtask

    task automatic step();
        exp_t e;
        @(posedge CLKI);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic run_to(input int rel);
        while (cyc < base + rel) step();
    endtask

    initial begin
        logic found;
        exp_t e;

        // Reset held with FORCE and all requests asserted
        RSTN = 1'b0; FORCE = 1'b1; CE_REQ = 4'hF;
        rstn2 = 1'b0; force2 = 1'b0; req2 = 4'h0;
        base = 0;
        for (int r = 1; r <= 3; r++) begin
            expect_at(r, K_OUT,  4'h0, "rst_out");
            expect_at(r, K_ACK,  4'h0, "rst_ack");
            expect_at(r, K_BUSY, 4'h0, "rst_busy");
        end
        expect_at(3, K_OUT2, 4'h0, "rst_out2");
        run_to(3);

        // Release: staggered rise on 0,1,2,3
        base = cyc; RSTN = 1'b1; FORCE = 1'b0;
        expect_at(2,  K_OUT,  4'h0, "rise_out");
        expect_at(3,  K_OUT,  4'h1, "rise_out");
        expect_at(7,  K_OUT,  4'h3, "rise_out");
        expect_at(11, K_OUT,  4'h7, "rise_out");
        expect_at(15, K_OUT,  4'hF, "rise_out");
        expect_at(16, K_ACK,  4'hF, "rise_ack");
        expect_at(17, K_BUSY, 4'h1, "rise_busy");
        expect_at(18, K_BUSY, 4'h0, "rise_busy");
        run_to(20);

        // Staggered fall after hold
        base = cyc; CE_REQ = 4'h0;
        expect_at(10, K_OUT,  4'hF, "fall_out");
        expect_at(11, K_OUT,  4'hE, "fall_out");
        expect_at(14, K_OUT,  4'hE, "fall_out");
        expect_at(15, K_OUT,  4'hC, "fall_out");
        expect_at(19, K_OUT,  4'h8, "fall_out");
        expect_at(23, K_OUT,  4'h0, "fall_out");
        expect_at(24, K_ACK,  4'h0, "fall_ack");
        expect_at(25, K_BUSY, 4'h1, "fall_busy");
        expect_at(26, K_BUSY, 4'h0, "fall_busy");
        run_to(28);

        // Single enable
        base = cyc; CE_REQ = 4'h1;
        expect_at(1, K_BUSY, 4'h0, "one_busy");
        expect_at(2, K_OUT,  4'h0, "one_out");
        expect_at(2, K_BUSY, 4'h1, "one_busy");
        expect_at(3, K_OUT,  4'h1, "one_out");
        expect_at(3, K_ACK,  4'h0, "one_ack");
        expect_at(4, K_ACK,  4'h1, "one_ack");
        expect_at(5, K_BUSY, 4'h1, "one_busy");
        expect_at(6, K_BUSY, 4'h0, "one_busy");
        run_to(10);

        // Short drop is absorbed by hysteresis
        base = cyc; CE_REQ = 4'h0;
        run_to(5);
        CE_REQ = 4'h1;
        expect_at(12, K_OUT, 4'h1, "hyst_short");
        expect_at(20, K_OUT, 4'h1, "hyst_short");
        run_to(20);

        // Long drop disables exactly 11 edges later, then re-enable
        base = cyc; CE_REQ = 4'h0;
        expect_at(10, K_OUT, 4'h1, "hyst_long");
        expect_at(11, K_OUT, 4'h0, "hyst_long");
        run_to(20);
        base = cyc; CE_REQ = 4'h1;
        expect_at(2, K_OUT, 4'h0, "reen_out");
        expect_at(3, K_OUT, 4'h1, "reen_out");
        run_to(8);

        // FORCE mid-sequence from a clean reset
        base = cyc; RSTN = 1'b0; CE_REQ = 4'h0;
        expect_at(1, K_OUT, 4'h0, "rst2_out");
        expect_at(1, K_ACK, 4'h0, "rst2_ack");
        run_to(1);
        base = cyc; RSTN = 1'b1; CE_REQ = 4'hF;
        expect_at(3, K_OUT, 4'h1, "frc_pre");
        expect_at(7, K_OUT, 4'h3, "frc_pre");
        expect_at(8, K_OUT, 4'h3, "frc_pre");
        run_to(8);
        FORCE = 1'b1; CE_REQ = 4'h0;
        expect_at(9, K_OUT,  4'hF, "frc_out");
        expect_at(9, K_BUSY, 4'h0, "frc_idle");
        run_to(9);
        FORCE = 1'b0;
        expect_at(18, K_OUT, 4'hF, "frc_drop");
        expect_at(19, K_OUT, 4'hB, "frc_drop");
        expect_at(23, K_OUT, 4'h3, "frc_drop");
        expect_at(27, K_OUT, 4'h2, "frc_drop");
        expect_at(31, K_OUT, 4'h0, "frc_drop");
        run_to(34);

        // Reset mid-sequence (pointer now at channel 2)
        base = cyc; CE_REQ = 4'hF;
        expect_at(8, K_OUT,  4'hC, "mid_pre");
        expect_at(8, K_ACK,  4'hC, "mid_pre");
        run_to(8);
        RSTN = 1'b0;
        expect_at(9, K_OUT,  4'h0, "mid_rst_out");
        expect_at(9, K_ACK,  4'h0, "mid_rst_ack");
        expect_at(9, K_BUSY, 4'h0, "mid_rst_busy");
        run_to(9);
        RSTN = 1'b1; CE_REQ = 4'h0;

        // Fairness with HOLD=0: channel 3 must get in despite channel 0 toggling
        base = cyc; rstn2 = 1'b1; req2 = 4'b1001;
        found = 1'b0;
        for (int n = 1; n <= 11 && !found; n++) begin
            step();
            if (out2[3] === 1'b1) found = 1'b1;
            if (n % 2 == 1) req2[0] = ~req2[0];
        end
        check("fair_ch3", {3'b000, found}, 4'h1);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s never reached observed=none expected=%h", e.tag, e.val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
